// File: rtl/input_loop_sequencer_if.sv
// Sequencer bus: start/bias request, tile-buffer reads, MAC operand/sum path, result handshake.
// Values are IEEE-754 single-precision bit patterns; master = sequencer, slave = environment.
interface input_loop_sequencer_if #(
  parameter int Tn_p = 4,
  parameter int N_p  = 16
);
  localparam int CHUNKS_lp = (N_p + Tn_p - 1) / Tn_p;
  localparam int CW_lp     = ($clog2(CHUNKS_lp + 1) > 1) ? $clog2(CHUNKS_lp + 1) : 1;

  logic                       start_v_i;
  logic                       start_ready_o;
  logic [31:0]                bias_i;
  logic                       buf_rd_v_o;
  logic [CW_lp-1:0]           buf_rd_addr_o;
  logic [Tn_p-1:0][31:0]      fm_buf_i;
  logic [Tn_p-1:0][31:0]      w_buf_i;
  logic [Tn_p-1:0][31:0]      mac_fm_o;
  logic [Tn_p-1:0][31:0]      mac_w_o;
  logic [31:0]                mac_init_o;
  logic [31:0]                mac_sum_i;
  logic                       result_v_o;
  logic [31:0]                result_o;
  logic                       result_yumi_i;
  logic                       busy_o;

  modport master (
    input  start_v_i, bias_i, fm_buf_i, w_buf_i, mac_sum_i, result_yumi_i,
    output start_ready_o, buf_rd_v_o, buf_rd_addr_o, mac_fm_o, mac_w_o,
           mac_init_o, result_v_o, result_o, busy_o
  );

  modport slave (
    output start_v_i, bias_i, fm_buf_i, w_buf_i, mac_sum_i, result_yumi_i,
    input  start_ready_o, buf_rd_v_o, buf_rd_addr_o, mac_fm_o, mac_w_o,
           mac_init_o, result_v_o, result_o, busy_o
  );
endinterface

// File: rtl/input_loop_sequencer.sv
// Drives the input_loop MAC over ceil(N_p/Tn_p) chunks for one output element; result_v_o at
// start+CHUNKS+2 cycles, held in DONE until yumi; start accepted only in IDLE.
module input_loop_sequencer #(
  parameter int Tn_p = 4,
  parameter int N_p  = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input_loop_sequencer_if.master seq_if_io
);
  localparam int CHUNKS_lp = (N_p + Tn_p - 1) / Tn_p;
  localparam int CW_lp     = ($clog2(CHUNKS_lp + 1) > 1) ? $clog2(CHUNKS_lp + 1) : 1;
  localparam logic [CW_lp-1:0] CHUNKS_CW_lp = CW_lp'(CHUNKS_lp);
  localparam logic [CW_lp-1:0] LAST_CW_lp   = CW_lp'(CHUNKS_lp - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CW_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW_lp-1:0] acc_cnt_q, acc_cnt_d;
  logic [CW_lp-1:0] chunk_q, chunk_d;
  logic             data_v_q, data_v_d;

  logic start_fire, read_fire, acc_fire, last_acc;

  assign start_fire = (state_q == IDLE) && seq_if_io.start_v_i;
  assign read_fire  = (state_q == RUN) && (rd_ptr_q < CHUNKS_CW_lp);
  assign acc_fire   = (state_q == RUN) && data_v_q;
  assign last_acc   = acc_fire && (acc_cnt_q == LAST_CW_lp);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_fire) state_d = RUN;
      RUN:     if (last_acc) state_d = DONE;
      DONE:    if (seq_if_io.result_yumi_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read of chunk k overlaps the accumulate of chunk k-1; rd_ptr stops at CHUNKS.
  always_comb begin
    acc_d     = acc_q;
    rd_ptr_d  = rd_ptr_q;
    acc_cnt_d = acc_cnt_q;
    chunk_d   = chunk_q;
    data_v_d  = read_fire;
    if (start_fire) begin
      acc_d     = seq_if_io.bias_i;
      rd_ptr_d  = '0;
      acc_cnt_d = '0;
    end
    if (read_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      chunk_d  = rd_ptr_q;
    end
    if (acc_fire) begin
      acc_d     = seq_if_io.mac_sum_i;
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q     <= '0;
      rd_ptr_q  <= '0;
      acc_cnt_q <= '0;
      chunk_q   <= '0;
      data_v_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      rd_ptr_q  <= rd_ptr_d;
      acc_cnt_q <= acc_cnt_d;
      chunk_q   <= chunk_d;
      data_v_q  <= data_v_d;
    end
  end

  always_comb begin
    seq_if_io.start_ready_o = (state_q == IDLE);
    seq_if_io.busy_o        = (state_q != IDLE);
    seq_if_io.buf_rd_v_o    = read_fire;
    seq_if_io.buf_rd_addr_o = rd_ptr_q;
    seq_if_io.mac_init_o    = acc_q;
    seq_if_io.result_v_o    = (state_q == DONE);
    seq_if_io.result_o      = acc_q;
    seq_if_io.mac_fm_o      = '0;
    seq_if_io.mac_w_o       = '0;
    // Lanes past the last real channel of the final chunk contribute exactly zero.
    for (int j = 0; j < Tn_p; j++) begin
      if (acc_fire && ((int'(chunk_q) * Tn_p + j) < N_p)) begin
        seq_if_io.mac_fm_o[j] = seq_if_io.fm_buf_i[j];
        seq_if_io.mac_w_o[j]  = seq_if_io.w_buf_i[j];
      end
    end
  end
endmodule

// File: tb/tb_input_loop_sequencer.sv
// Bench for input_loop_sequencer: two instances (Tn=3,N=3 and Tn=3,N=7) with buffer and MAC models.
module tb_input_loop_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  real sb[$];

  input_loop_sequencer_if #(.Tn_p(3), .N_p(3)) ifa ();
  input_loop_sequencer_if #(.Tn_p(3), .N_p(7)) ifb ();

  input_loop_sequencer #(.Tn_p(3), .N_p(3)) u_a (.clk_i(clk), .reset_n_i(rst_n), .seq_if_io(ifa));
  input_loop_sequencer #(.Tn_p(3), .N_p(7)) u_b (.clk_i(clk), .reset_n_i(rst_n), .seq_if_io(ifb));

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'd0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic real s2r(input logic [31:0] s);
    if (s[30:23] == 8'd0) return 0.0;
    return $bitstoreal({s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0});
  endfunction

  function automatic logic [2:0][31:0] pack3(input real l0, input real l1, input real l2);
    return {r2s(l2), r2s(l1), r2s(l0)};
  endfunction

  function automatic logic [31:0] mac3(input logic [31:0] init, input logic [2:0][31:0] f,
                                       input logic [2:0][31:0] w);
    real s;
    s = s2r(init);
    for (int j = 0; j < 3; j++) s += s2r(f[j]) * s2r(w[j]);
    return r2s(s);
  endfunction

  logic              start_v [2];
  logic [31:0]       bias_v  [2];
  logic              yumi    [2];
  logic [2:0][31:0]  fm_mem  [2][3];
  logic [2:0][31:0]  w_mem   [2][3];

  logic             rd_v [2], ready [2], res_v [2], busy [2];
  logic [1:0]       rd_addr [2];
  logic [31:0]      res [2], macinit [2];
  logic [2:0][31:0] macfm [2], macw [2];

  assign ifa.start_v_i     = start_v[0];
  assign ifb.start_v_i     = start_v[1];
  assign ifa.bias_i        = bias_v[0];
  assign ifb.bias_i        = bias_v[1];
  assign ifa.result_yumi_i = yumi[0];
  assign ifb.result_yumi_i = yumi[1];
  assign ifa.mac_sum_i     = mac3(ifa.mac_init_o, ifa.mac_fm_o, ifa.mac_w_o);
  assign ifb.mac_sum_i     = mac3(ifb.mac_init_o, ifb.mac_fm_o, ifb.mac_w_o);

  always @(posedge clk) begin
    if (ifa.buf_rd_v_o) begin
      ifa.fm_buf_i <= fm_mem[0][ifa.buf_rd_addr_o];
      ifa.w_buf_i  <= w_mem[0][ifa.buf_rd_addr_o];
    end
    if (ifb.buf_rd_v_o) begin
      ifb.fm_buf_i <= fm_mem[1][ifb.buf_rd_addr_o];
      ifb.w_buf_i  <= w_mem[1][ifb.buf_rd_addr_o];
    end
  end

  assign rd_v[0] = ifa.buf_rd_v_o;      assign rd_v[1] = ifb.buf_rd_v_o;
  assign rd_addr[0] = {1'b0, ifa.buf_rd_addr_o};
  assign rd_addr[1] = ifb.buf_rd_addr_o;
  assign ready[0] = ifa.start_ready_o;  assign ready[1] = ifb.start_ready_o;
  assign res_v[0] = ifa.result_v_o;     assign res_v[1] = ifb.result_v_o;
  assign res[0] = ifa.result_o;         assign res[1] = ifb.result_o;
  assign busy[0] = ifa.busy_o;          assign busy[1] = ifb.busy_o;
  assign macinit[0] = ifa.mac_init_o;   assign macinit[1] = ifb.mac_init_o;
  assign macfm[0] = ifa.mac_fm_o;       assign macfm[1] = ifb.mac_fm_o;
  assign macw[0] = ifa.mac_w_o;         assign macw[1] = ifb.mac_w_o;

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ready[d] !== 1'b1 || rd_v[d] !== 1'b0 || rd_addr[d] !== 2'd0 || res_v[d] !== 1'b0 ||
          res[d] !== 32'd0 || busy[d] !== 1'b0 || macinit[d] !== 32'd0 ||
          macfm[d] !== '0 || macw[d] !== '0)
        $display("FAIL %s dut%0d: ready=%b rd_v=%b addr=%0d res_v=%b res=%h busy=%b init=%h fm=%h w=%h, need 1 0 0 0 0 0 0 0 0",
                 tag, d, ready[d], rd_v[d], rd_addr[d], res_v[d], res[d], busy[d], macinit[d], macfm[d], macw[d]);
      if (ready[d] !== 1'b1 || rd_v[d] !== 1'b0 || rd_addr[d] !== 2'd0 || res_v[d] !== 1'b0 ||
          res[d] !== 32'd0 || busy[d] !== 1'b0 || macinit[d] !== 32'd0 ||
          macfm[d] !== '0 || macw[d] !== '0)
        errors++;
    end
  endtask

  // Runs one element from an IDLE negedge; leaves the bench at the negedge after yumi with DUT idle.
  task automatic do_element(input int d, input real bias, input int hold, input bit busy_pulse);
    int chunks;
    int cyc;
    real expv;
    real got;
    logic [31:0] held;
    chunks = (d == 0) ? 1 : 3;
    start_v[d] = 1'b1;
    bias_v[d]  = r2s(bias);
    @(negedge clk);
    start_v[d] = 1'b0;
    cyc = 1;
    checks++;
    if (busy[d] !== 1'b1) begin
      errors++; $display("FAIL busy_after_start dut%0d: busy=%b need 1", d, busy[d]);
    end
    while (res_v[d] !== 1'b1 && cyc < 40) begin
      checks++;
      if (rd_v[d] !== (cyc <= chunks)) begin
        errors++; $display("FAIL rd_v dut%0d cycle %0d: got %b need %b", d, cyc, rd_v[d], (cyc <= chunks));
      end
      if (rd_v[d] === 1'b1) begin
        checks++;
        if (rd_addr[d] !== 2'(cyc - 1)) begin
          errors++; $display("FAIL rd_addr dut%0d cycle %0d: got %0d need %0d", d, cyc, rd_addr[d], cyc - 1);
        end
      end
      if (d == 1 && cyc == chunks + 1) begin
        checks++;
        if (macfm[1][1] !== 32'd0 || macfm[1][2] !== 32'd0 || macw[1][1] !== 32'd0 || macw[1][2] !== 32'd0) begin
          errors++; $display("FAIL lane_mask: fm=%h w=%h need lanes 1,2 zero", macfm[1], macw[1]);
        end
      end
      if (busy_pulse && cyc == 2) begin
        checks++;
        if (ready[d] !== 1'b0) begin
          errors++; $display("FAIL ready_in_run: got %b need 0", ready[d]);
        end
        start_v[d] = 1'b1;
        bias_v[d]  = r2s(99.0);
      end else if (cyc == 3) begin
        start_v[d] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_v[d] = 1'b0;
    checks++;
    if (res_v[d] !== 1'b1 || cyc != chunks + 2) begin
      errors++; $display("FAIL result_latency dut%0d: result_v=%b at cycle %0d need 1 at %0d", d, res_v[d], cyc, chunks + 2);
    end
    if (res_v[d] !== 1'b1) return;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL scoreboard dut%0d: result with no expectation", d);
    end else begin
      expv = sb.pop_front();
      got  = s2r(res[d]);
      if (got - expv > 1.0e-3 || expv - got > 1.0e-3) begin
        errors++; $display("FAIL result dut%0d: got %f need %f", d, got, expv);
      end
    end
    held = res[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (res_v[d] !== 1'b1 || res[d] !== held || ready[d] !== 1'b0 || rd_v[d] !== 1'b0) begin
        errors++; $display("FAIL backpressure dut%0d: res_v=%b res=%h ready=%b rd_v=%b need 1 %h 0 0",
                           d, res_v[d], res[d], ready[d], rd_v[d], held);
      end
    end
    yumi[d] = 1'b1;
    @(negedge clk);
    yumi[d] = 1'b0;
    checks++;
    if (res_v[d] !== 1'b0 || ready[d] !== 1'b1) begin
      errors++; $display("FAIL yumi_to_idle dut%0d: res_v=%b ready=%b need 0 1", d, res_v[d], ready[d]);
    end
  endtask

  task automatic load_scn1_b();
    fm_mem[1][0] = pack3(7.2, 5.0, 20.0);  w_mem[1][0] = pack3(10.0, 10.0, 10.0);
    fm_mem[1][1] = '0;                     w_mem[1][1] = '0;
    fm_mem[1][2] = '0;                     w_mem[1][2] = '0;
  endtask

  task automatic load_scn3_b();
    for (int a = 0; a < 3; a++) begin
      fm_mem[1][a] = pack3(1.0, 1.0, 1.0);
      w_mem[1][a]  = pack3(2.0, 2.0, 2.0);
    end
    fm_mem[1][2] = pack3(1.0, 100.0, 100.0);
    w_mem[1][2]  = pack3(2.0, 100.0, 100.0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_release");
  endtask

  task automatic test_single_chunk();
    fm_mem[0][0] = pack3(7.2, 5.0, 20.0);  w_mem[0][0] = pack3(10.0, 10.0, 10.0);
    sb.push_back(322.0);   do_element(0, 0.0, 0, 1'b0);
    sb.push_back(323.54);  do_element(0, 1.54, 0, 1'b0);
    fm_mem[0][0] = pack3(7.2, 7.2, 1.72);  w_mem[0][0] = pack3(10.0, 5.0, 0.0);
    sb.push_back(108.0);   do_element(0, 0.0, 0, 1'b0);
  endtask

  task automatic test_masked_lanes();
    load_scn3_b();
    sb.push_back(14.0);
    do_element(1, 0.0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    load_scn3_b();
    sb.push_back(14.0);
    do_element(1, 0.0, 5, 1'b0);
  endtask

  task automatic test_start_while_busy();
    load_scn3_b();
    sb.push_back(14.0);
    do_element(1, 0.0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    load_scn3_b();
    start_v[1] = 1'b1;
    bias_v[1]  = r2s(0.0);
    @(negedge clk);
    start_v[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_v[1] !== 1'b0 || ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
      errors++; $display("FAIL abort_idle: rd_v=%b ready=%b busy=%b need 0 1 0", rd_v[1], ready[1], busy[1]);
    end
    load_scn1_b();
    sb.push_back(322.0);
    do_element(1, 0.0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int f, w, b;
    real expv;
    for (int e = 0; e < 4; e++) begin
      b = $urandom_range(0, 9);
      expv = real'(b);
      for (int a = 0; a < 3; a++) begin
        for (int j = 0; j < 3; j++) begin
          f = $urandom_range(1, 9);
          w = $urandom_range(1, 9);
          fm_mem[1][a][j] = r2s(real'(f));
          w_mem[1][a][j]  = r2s(real'(w));
          if (a * 3 + j < 7) expv += real'(f * w);
        end
      end
      sb.push_back(expv);
      do_element(1, real'(b), 0, 1'b0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0;
      bias_v[d]  = 32'd0;
      yumi[d]    = 1'b0;
      for (int a = 0; a < 3; a++) begin
        fm_mem[d][a] = '0;
        w_mem[d][a]  = '0;
      end
    end
    test_reset();
    test_single_chunk();
    test_masked_lanes();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d results never produced, need 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
